// File: rtl/mul_sweep_driver.sv
// Sweeps every operand pair into a multiplier under test and collects error
// statistics against the exact product, behind a start/done handshake.
module mul_sweep_driver #(
  parameter int WIDTH  = 6,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 2*WIDTH+1,
  parameter int ACC_W  = 4*WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   mul_in1,
  output logic [WIDTH-1:0]   mul_in2,
  input  logic [2*WIDTH-1:0] mul_out,
  input  logic               mul_overflow,
  output logic [CNT_W-1:0]   err_count,
  output logic [2*WIDTH-1:0] max_ed,
  output logic [ACC_W-1:0]   sum_ed,
  output logic               ovf_seen
);

  localparam int PW          = 2*WIDTH;
  localparam int SET_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  // With SETTLE=0 the operands are sampled in the same cycle they are driven.
  localparam state_t S_PAIR = (SETTLE > 0) ? S_DRIVE : S_SAMPLE;
  localparam logic [WIDTH-1:0] OP_MAX = '1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic [PW-1:0]      max_ed_q, max_ed_d;
  logic [ACC_W-1:0]   sum_ed_q, sum_ed_d;
  logic               ovf_seen_q, ovf_seen_d;

  logic [PW-1:0]      exact;
  logic [PW-1:0]      ed;

  assign exact = PW'(a_q) * PW'(b_q);
  assign ed    = (mul_out >= exact) ? (mul_out - exact) : (exact - mul_out);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      settle_q    <= '0;
      err_count_q <= '0;
      max_ed_q    <= '0;
      sum_ed_q    <= '0;
      ovf_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      settle_q    <= settle_d;
      err_count_q <= err_count_d;
      max_ed_q    <= max_ed_d;
      sum_ed_q    <= sum_ed_d;
      ovf_seen_q  <= ovf_seen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    settle_d    = settle_q;
    err_count_d = err_count_q;
    max_ed_d    = max_ed_q;
    sum_ed_d    = sum_ed_q;
    ovf_seen_d  = ovf_seen_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_count_d = '0;
          max_ed_d    = '0;
          sum_ed_d    = '0;
          ovf_seen_d  = 1'b0;
          a_d         = '0;
          b_d         = '0;
          settle_d    = '0;
          state_d     = S_PAIR;
        end
      end
      S_DRIVE: begin
        if (settle_q == SET_W'(SETTLE_LAST)) begin
          state_d = S_SAMPLE;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      S_SAMPLE: begin
        err_count_d = err_count_q + CNT_W'(ed != '0);
        max_ed_d    = (ed > max_ed_q) ? ed : max_ed_q;
        sum_ed_d    = sum_ed_q + ACC_W'(ed);
        ovf_seen_d  = ovf_seen_q | mul_overflow;
        if (a_q == OP_MAX && b_q == OP_MAX) begin
          state_d = S_DONE;
        end else begin
          // b is the inner loop, a the outer loop
          if (b_q == OP_MAX) begin
            b_d = '0;
            a_d = a_q + WIDTH'(1);
          end else begin
            b_d = b_q + WIDTH'(1);
          end
          settle_d = '0;
          state_d  = S_PAIR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    mul_in1 = '0;
    mul_in2 = '0;
    case (state_q)
      S_DRIVE, S_SAMPLE: begin
        busy    = 1'b1;
        mul_in1 = a_q;
        mul_in2 = b_q;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign err_count = err_count_q;
  assign max_ed    = max_ed_q;
  assign sum_ed    = sum_ed_q;
  assign ovf_seen  = ovf_seen_q;

endmodule

// File: tb/tb_mul_sweep_driver.sv
// Directed bench: two sweep drivers (SETTLE=1 and SETTLE=0) against a
// behavioural multiplier whose error behaviour is selected per sweep.
module tb_mul_sweep_driver;

  localparam int W = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  int   mode  = 0;  // 0 exact, 1 bit0 cleared, 2 zero, 3 exact + overflow at (63,63)

  // SETTLE=1 instance
  logic          start1 = 1'b0;
  logic          busy1, done1, ovf1_in, ovf_seen1;
  logic [W-1:0]  in1_1, in2_1;
  logic [2*W-1:0] out1, max1;
  logic [2*W:0]  err1;
  logic [4*W-1:0] sum1;

  // SETTLE=0 instance
  logic          start0 = 1'b0;
  logic          busy0, done0, ovf0_in, ovf_seen0;
  logic [W-1:0]  in1_0, in2_0;
  logic [2*W-1:0] out0, max0;
  logic [2*W:0]  err0;
  logic [4*W-1:0] sum0;

  mul_sweep_driver #(.WIDTH(W), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .mul_in1(in1_1), .mul_in2(in2_1), .mul_out(out1), .mul_overflow(ovf1_in),
    .err_count(err1), .max_ed(max1), .sum_ed(sum1), .ovf_seen(ovf_seen1)
  );

  mul_sweep_driver #(.WIDTH(W), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
    .mul_in1(in1_0), .mul_in2(in2_0), .mul_out(out0), .mul_overflow(ovf0_in),
    .err_count(err0), .max_ed(max0), .sum_ed(sum0), .ovf_seen(ovf_seen0)
  );

  function automatic logic [2*W-1:0] model_out(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = (2*W)'(x) * (2*W)'(y);
    case (mode)
      1:       return {p[2*W-1:1], 1'b0};
      2:       return '0;
      default: return p;
    endcase
  endfunction

  always_comb begin
    out1    = model_out(in1_1, in2_1);
    out0    = model_out(in1_0, in2_0);
    ovf1_in = (mode == 3) && (in1_1 == 6'd63) && (in2_1 == 6'd63);
    ovf0_in = (mode == 3) && (in1_0 == 6'd63) && (in2_0 == 6'd63);
  end

  // Selected-instance view used by the sweep task
  logic           sel0 = 1'b0;
  logic           busy_m, done_m, ovf_m;
  logic [2*W:0]   err_m;
  logic [2*W-1:0] max_m;
  logic [4*W-1:0] sum_m;
  assign busy_m = sel0 ? busy0 : busy1;
  assign done_m = sel0 ? done0 : done1;
  assign ovf_m  = sel0 ? ovf_seen0 : ovf_seen1;
  assign err_m  = sel0 ? err0 : err1;
  assign max_m  = sel0 ? max0 : max1;
  assign sum_m  = sel0 ? sum0 : sum1;

  int n_cmp = 0;
  int n_bad = 0;
  int overlap = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel0) start0 = v; else start1 = v;
  endtask

  // Starts a sweep and measures edges from the start edge until done is seen.
  task automatic run_sweep(input string tag, input int exp_cyc, input int pulse_at);
    int cyc;
    bit seen;
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 20000) begin
      set_start(pulse_at != 0 && (cyc == pulse_at || cyc == 3*pulse_at));
      @(posedge clk); #1;
      cyc++;
      if (busy_m && done_m) overlap++;
      if (done_m) seen = 1;
    end
    set_start(1'b0);
    check({tag, "_done_latency"}, cyc, exp_cyc);
    check({tag, "_busy_at_done"}, busy_m, 0);
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, done_m, 0);
  endtask

  task automatic check_stats(input string tag, input longint e, input longint m,
                             input longint s, input longint o);
    check({tag, "_err_count"}, err_m, e);
    check({tag, "_max_ed"},    max_m, m);
    check({tag, "_sum_ed"},    sum_m, s);
    check({tag, "_ovf_seen"},  ovf_m, o);
  endtask

  initial begin
    int dones;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_busy",  busy1, 0);
    check("rst_done",  done1, 0);
    check("rst_in1",   in1_1, 0);
    check("rst_err",   err1,  0);
    check("rst_sum",   sum1,  0);
    check("rst_busy0", busy0, 0);

    sel0 = 1'b0;
    mode = 0; run_sweep("exact", 8192, 0); check_stats("exact", 0, 0, 0, 0);
    mode = 1; run_sweep("bit0",  8192, 0); check_stats("bit0", 1024, 1, 1024, 0);
    mode = 2; run_sweep("zero",  8192, 0); check_stats("zero", 3969, 3969, 4064256, 0);
    mode = 3; run_sweep("ovf",   8192, 0); check_stats("ovf", 0, 0, 0, 1);
    mode = 0; run_sweep("reovf", 8192, 0); check_stats("reovf", 0, 0, 0, 0);

    sel0 = 1'b1;
    mode = 2; run_sweep("s0_zero",  4096, 100); check_stats("s0_zero", 3969, 3969, 4064256, 0);
    mode = 0; run_sweep("s0_exact", 4096, 100); check_stats("s0_exact", 0, 0, 0, 0);

    // Abort a sweep around pair 2000 with a one-edge reset
    sel0 = 1'b0;
    mode = 2;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (4000) @(negedge clk);
    check("mid_busy_before_rst", busy1, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_busy", busy1, 0);
    check_stats("mid_rst", 0, 0, 0, 0);
    dones = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (done1) dones++;
    end
    check("mid_rst_no_done", dones, 0);
    run_sweep("fresh", 8192, 0); check_stats("fresh", 3969, 3969, 4064256, 0);

    check("busy_done_overlap", overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
